pool_engine: RTL and testbench

Parametrised 2x2 stride-2 max-pooling engine for the layer-memory datapath, the successor to the fixed two-channel, 64x64 pooling stage. It reads CH feature maps of IMG_W x IMG_H words through the shared `crd`/`caddr_rd`/`csel` port and writes one pooled word per window per channel through `cwr`/`caddr_wr`. Comparison is signed. A start/done handshake replaces free-running enables. Optionally the results are written interleaved into a single flatten memory.

---
 rtl/pool_engine.sv | 159 +++++++++++++++
 tb/tb_pool_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_engine.sv
// 2x2 stride-2 signed max-pooling engine over CH feature maps with a start/done handshake.
// Define POOL_FLATTEN_EN to write channel-interleaved results into the FLAT_SEL memory.
module pool_engine #(
  parameter int DW       = 20,
  parameter int AW       = 12,
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int CH       = 2,
  parameter int SRC_SEL  = 1,
  parameter int DST_SEL  = 3,
  parameter int FLAT_SEL = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  localparam int WC  = IMG_W / 2;
  localparam int WRN = IMG_H / 2;
  localparam int CW  = (WC > 1) ? $clog2(WC) : 1;
  localparam int RW  = (WRN > 1) ? $clog2(WRN) : 1;
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [2:0] {IDLE, R0, R1, R2, R3, WR, DONE} state_t;

  state_t state, state_next;

  logic [RW-1:0]         win_r;
  logic [CW-1:0]         win_c;
  logic [CHW-1:0]        ch;
  logic signed [DW-1:0]  acc;
  logic signed [DW-1:0]  pooled;
  logic [AW-1:0]         base;
  logic [AW-1:0]         rd_addr;
  logic [AW-1:0]         rd_last;
  logic [AW-1:0]         out_idx;
  logic                  last_ch, last_c, last_r;

  assign last_ch = (int'(ch) == CH - 1);
  assign last_c  = (int'(win_c) == WC - 1);
  assign last_r  = (int'(win_r) == WRN - 1);
  assign base    = AW'(2 * int'(win_r) * IMG_W + 2 * int'(win_c));
  assign out_idx = AW'(int'(win_r) * WC + int'(win_c));
  // Ties keep acc; R3 data arrives during WR and is folded in combinationally.
  assign pooled  = ($signed(cdata_rd) > acc) ? $signed(cdata_rd) : acc;

  always_comb begin
    case (state)
      R0:      rd_addr = base;
      R1:      rd_addr = base + AW'(1);
      R2:      rd_addr = base + AW'(IMG_W);
      R3:      rd_addr = base + AW'(IMG_W + 1);
      default: rd_addr = rd_last;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_r   <= '0;
      win_c   <= '0;
      ch      <= '0;
      acc     <= '0;
      rd_last <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          win_r <= '0;
          win_c <= '0;
          ch    <= '0;
        end
        R0: rd_last <= rd_addr;
        R1: begin
          rd_last <= rd_addr;
          acc     <= $signed(cdata_rd);
        end
        R2, R3: begin
          rd_last <= rd_addr;
          acc     <= pooled;
        end
        WR: begin
          if (!last_ch) begin
            ch <= ch + CHW'(1);
          end else begin
            ch <= '0;
            if (last_c) begin
              win_c <= '0;
              win_r <= last_r ? '0 : win_r + RW'(1);
            end else begin
              win_c <= win_c + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? R0 : IDLE;
      R0:      state_next = R1;
      R1:      state_next = R2;
      R2:      state_next = R3;
      R3:      state_next = WR;
      WR:      state_next = (last_ch && last_c && last_r) ? DONE : R0;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    crd      = 1'b0;
    cwr      = 1'b0;
    caddr_rd = rd_last;
    caddr_wr = '0;
    cdata_wr = '0;
    csel     = '0;
    case (state)
      R0, R1, R2, R3: begin
        busy     = 1'b1;
        crd      = 1'b1;
        caddr_rd = rd_addr;
        csel     = 3'(SRC_SEL + int'(ch));
      end
      WR: begin
        busy     = 1'b1;
        cwr      = 1'b1;
        cdata_wr = pooled;
`ifdef POOL_FLATTEN_EN
        csel     = 3'(FLAT_SEL);
        caddr_wr = AW'(int'(out_idx) * CH + int'(ch));
`else
        csel     = 3'(DST_SEL + int'(ch));
        caddr_wr = out_idx;
`endif
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pool_engine.sv
// Bench for pool_engine: a 4x4 instance for directed ramp/negative/handshake/reset cases
// and a default 64x64 instance with random signed data, both checked against a window-max model.
module tb_pool_engine;

  typedef logic [34:0] wr_t;  // {csel, addr, data}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_reset = 1'b1, s_start = 1'b0;
  logic        s_busy, s_done, s_crd, s_cwr;
  logic [11:0] s_caddr_rd, s_caddr_wr;
  logic [19:0] s_cdata_rd, s_cdata_wr;
  logic [2:0]  s_csel;

  logic        b_reset = 1'b1, b_start = 1'b0;
  logic        b_busy, b_done, b_crd, b_cwr;
  logic [11:0] b_caddr_rd, b_caddr_wr;
  logic [19:0] b_cdata_rd, b_cdata_wr;
  logic [2:0]  b_csel;

  logic [19:0] smem [0:1][0:4095];
  logic [19:0] bmem [0:1][0:4095];
  wr_t         s_wq[$];
  wr_t         b_wq[$];
  wr_t         exp_q[$];
  int          s_overlap = 0;
  int          b_overlap = 0;
  int          checks = 0;
  int          errors = 0;

  pool_engine #(.IMG_W(4), .IMG_H(4), .CH(2)) u_small (
    .clk(clk), .reset(s_reset), .start(s_start), .busy(s_busy), .done(s_done),
    .crd(s_crd), .caddr_rd(s_caddr_rd), .cdata_rd(s_cdata_rd), .cwr(s_cwr),
    .caddr_wr(s_caddr_wr), .cdata_wr(s_cdata_wr), .csel(s_csel)
  );

  pool_engine u_big (
    .clk(clk), .reset(b_reset), .start(b_start), .busy(b_busy), .done(b_done),
    .crd(b_crd), .caddr_rd(b_caddr_rd), .cdata_rd(b_cdata_rd), .cwr(b_cwr),
    .caddr_wr(b_caddr_wr), .cdata_wr(b_cdata_wr), .csel(b_csel)
  );

  // Memory models: one-cycle read latency, every write logged in order.
  always @(posedge clk) begin
    if (s_crd) s_cdata_rd <= (s_csel == 3'd1 || s_csel == 3'd2) ? smem[s_csel - 3'd1][s_caddr_rd] : 'x;
    if (s_cwr) s_wq.push_back({s_csel, s_caddr_wr, s_cdata_wr});
    if (s_crd && s_cwr) s_overlap++;
    if (b_crd) b_cdata_rd <= (b_csel == 3'd1 || b_csel == 3'd2) ? bmem[b_csel - 3'd1][b_caddr_rd] : 'x;
    if (b_cwr) b_wq.push_back({b_csel, b_caddr_wr, b_cdata_wr});
    if (b_crd && b_cwr) b_overlap++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs_s();
    return 64'({s_busy, s_done, s_crd, s_cwr, s_caddr_rd, s_caddr_wr, s_cdata_wr, s_csel});
  endfunction

  function automatic logic [63:0] outs_b();
    return 64'({b_busy, b_done, b_crd, b_cwr, b_caddr_rd, b_caddr_wr, b_cdata_wr, b_csel});
  endfunction

  function automatic logic signed [19:0] pix(input bit big, input int c, input int a);
    return big ? bmem[c][a] : smem[c][a];
  endfunction

  // Reference: every 2x2 window, max of its four signed samples, in channel-innermost order.
  task automatic build_exp(input bit big, input int w, input int h, input int nch);
    exp_q.delete();
    for (int r = 0; r < h / 2; r++)
      for (int c = 0; c < w / 2; c++)
        for (int k = 0; k < nch; k++) begin
          int a;
          int idx;
          logic signed [19:0] m;
          logic signed [19:0] v [4];
          wr_t e;
          a = 2 * r * w + 2 * c;
          v[0] = pix(big, k, a);
          v[1] = pix(big, k, a + 1);
          v[2] = pix(big, k, a + w);
          v[3] = pix(big, k, a + w + 1);
          m = v[0];
          for (int j = 1; j < 4; j++) if (v[j] > m) m = v[j];
          idx = r * (w / 2) + c;
`ifdef POOL_FLATTEN_EN
          e = {3'd5, 12'(idx * nch + k), m};
`else
          e = {3'(3 + k), 12'(idx), m};
`endif
          exp_q.push_back(e);
        end
  endtask

  task automatic cmp_q(input string tag, input bit big, input int base);
    int n;
    n = (big ? b_wq.size() : s_wq.size()) - base;
    chk({tag, "_count"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk({tag, "_wr"}, 64'(big ? b_wq[base + i] : s_wq[base + i]), 64'(exp_q[i]));
  endtask

  task automatic ramp_consts(input int base);
    int r0 [4];
    r0 = '{5, 7, 13, 15};
    for (int i = base; i < s_wq.size(); i++) begin
      wr_t w;
      int  a, k, idx, e;
      logic [2:0] es;
      w = s_wq[i];
      a = int'(w[31:20]);
`ifdef POOL_FLATTEN_EN
      k = a % 2;
      idx = a / 2;
      es = 3'd5;
`else
      k = int'(w[34:32]) - 3;
      idx = a;
      es = 3'(3 + k);
`endif
      e = (idx < 4 && k == 0) ? r0[idx] : (idx < 4 && k == 1) ? r0[3 - idx] : -1;
      chk("ramp_const", 64'({w[34:32], w[19:0]}), 64'({es, 20'(e)}));
    end
  endtask

  task automatic run_small(input string tag, input int pa, input int pb, input int rst_at);
    int n;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk({tag, "_first_r0"}, 64'({s_busy, s_crd, s_csel, s_caddr_rd}), 64'({1'b1, 1'b1, 3'd1, 12'd0}));
    n = 1;
    while (n < 200) begin
      s_start = (n == pa || n == pb);
      if (n == rst_at) begin
        s_reset = 1'b1;
        tick();
        s_reset = 1'b0;
        s_start = 1'b0;
        chk({tag, "_reset_outs"}, outs_s(), 64'd0);
        return;
      end
      tick();
      if (!s_busy) break;
      n++;
    end
    s_start = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(n), 64'd40);
    chk({tag, "_done_cycle"}, 64'({s_done, s_crd, s_cwr, s_csel}), 64'({1'b1, 1'b0, 1'b0, 3'd0}));
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk({tag, "_start_in_done_ignored"}, 64'({s_busy, s_done, s_crd}), 64'd0);
    tick();
    chk({tag, "_stays_idle"}, 64'({s_busy, s_done, s_crd, s_cwr}), 64'd0);
  endtask

  initial begin
    int base;
    int n;
    for (int i = 0; i < 16; i++) begin
      smem[0][i] = 20'(i);
      smem[1][i] = 20'(15 - i);
    end

    tick();
    tick();
    chk("reset_outs_small", outs_s(), 64'd0);
    chk("reset_outs_big", outs_b(), 64'd0);
    s_reset = 1'b0;
    b_reset = 1'b0;
    tick();
    chk("idle_no_start", 64'({s_busy, s_crd, s_cwr}), 64'd0);

    // Ramp
    base = s_wq.size();
    run_small("ramp", -1, -1, -1);
    build_exp(1'b0, 4, 4, 2);
    cmp_q("ramp", 1'b0, base);
    ramp_consts(base);

    // Start pulses while busy
    base = s_wq.size();
    run_small("handshake", 3, 20, -1);
    cmp_q("handshake", 1'b0, base);

    // Reset during channel 0 of window 1
    base = s_wq.size();
    run_small("midreset", -1, -1, 12);
    for (int i = 0; i < 10; i++) tick();
    chk("midreset_writes", 64'(s_wq.size() - base), 64'd2);
    chk("midreset_idle", 64'({s_busy, s_done}), 64'd0);
    base = s_wq.size();
    run_small("restart", -1, -1, -1);
    cmp_q("restart", 1'b0, base);
    ramp_consts(base);

    // All-negative windows with a single -1 per window
    for (int i = 0; i < 16; i++) begin
      smem[0][i] = 20'h80000;
      smem[1][i] = 20'($urandom);
    end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        int p;
        p = int'($urandom_range(0, 3));
        smem[0][2 * r * 4 + 2 * c + (p % 2) + (p / 2) * 4] = 20'hFFFFF;
      end
    base = s_wq.size();
    run_small("negative", -1, -1, -1);
    build_exp(1'b0, 4, 4, 2);
    cmp_q("negative", 1'b0, base);
    for (int i = base; i < s_wq.size(); i++) begin
      wr_t w;
      w = s_wq[i];
`ifdef POOL_FLATTEN_EN
      if (w[20] == 1'b0) chk("negative_ch0", 64'(w[19:0]), 64'hFFFFF);
`else
      if (w[34:32] == 3'd3) chk("negative_ch0", 64'(w[19:0]), 64'h FFFFF);
`endif
    end

    // Default geometry, random signed data
    for (int i = 0; i < 4096; i++) begin
      bmem[0][i] = 20'($urandom);
      bmem[1][i] = 20'($urandom);
    end
    base = b_wq.size();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("big_first_r0", 64'({b_busy, b_crd, b_csel}), 64'({1'b1, 1'b1, 3'd1}));
    n = 1;
    while (n < 20000) begin
      tick();
      if (!b_busy) break;
      n++;
    end
    chk("big_busy_cycles", 64'(n), 64'd10240);
    chk("big_done", 64'({b_done, b_csel}), 64'({1'b1, 3'd0}));
    tick();
    chk("big_done_pulse", 64'({b_done, b_busy}), 64'd0);
    build_exp(1'b1, 64, 64, 2);
    cmp_q("big", 1'b1, base);

    chk("read_write_overlap", 64'(s_overlap + b_overlap), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
